// File: rtl/duty_sequencer_if.sv
// Duty sequencer control/status bundle.
// Master drives control; slave returns the duty word and status.
interface duty_seq_if #(
  parameter int BIT_RES = 3
);
  logic               enable;
  logic               manual;
  logic [BIT_RES-1:0] manual_value;
  logic [BIT_RES-1:0] duty;
  logic               duty_update;
  logic               busy;
  logic               cycle_done;

  modport master (
    output enable,
    output manual,
    output manual_value,
    input  duty,
    input  duty_update,
    input  busy,
    input  cycle_done
  );

  modport slave (
    input  enable,
    input  manual,
    input  manual_value,
    output duty,
    output duty_update,
    output busy,
    output cycle_done
  );
endinterface

// File: rtl/duty_sequencer.sv
// Breathing duty-word generator feeding the PWM driver.
// Ramp up, hold high, ramp down, hold low; manual override bypass.
module duty_sequencer #(
  parameter int BIT_RES    = 3,
  parameter int STEP_DIV   = 83333,
  parameter int HOLD_STEPS = 4
) (
  input  logic      clk,
  input  logic      reset,
  duty_seq_if.slave bus
);

  localparam int PW =
    (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int HW =
    (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;

  localparam logic [BIT_RES-1:0] MAX  = '1;
  localparam logic [BIT_RES-1:0] ZERO = '0;
  localparam logic [BIT_RES-1:0] ONE  = BIT_RES'(1);
  localparam logic [PW-1:0] P_LAST = PW'(STEP_DIV - 1);
  localparam logic [PW-1:0] P_ONE  = PW'(1);
  localparam logic [HW-1:0] H_LAST = HW'(HOLD_STEPS - 1);
  localparam logic [HW-1:0] H_ONE  = HW'(1);

  typedef enum logic [2:0] {
    IDLE,
    UP,
    HOLD_HI,
    DOWN,
    HOLD_LO
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [PW-1:0]      presc_q;
  logic [PW-1:0]      presc_d;
  logic [HW-1:0]      hold_q;
  logic [HW-1:0]      hold_d;
  logic [BIT_RES-1:0] duty_q;
  logic [BIT_RES-1:0] duty_d;
  logic [BIT_RES-1:0] duty_inc;
  logic [BIT_RES-1:0] duty_dec;
  logic               upd_q;
  logic               busy_q;
  logic               done_q;
  logic               done_d;
  logic               tick;
  logic               stop;

  assign stop     = bus.manual || !bus.enable;
  assign tick     = (state_q != IDLE) &&
                    (presc_q == P_LAST);
  assign duty_inc = duty_q + ONE;
  assign duty_dec = duty_q - ONE;

  // Step prescaler: free-runs only while breathing
  always_comb begin
    presc_d = presc_q;
    if (stop || state_q == IDLE || tick)
      presc_d = '0;
    else
      presc_d = presc_q + P_ONE;
  end

  // Breathing FSM with manual/disable priority
  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    hold_d  = hold_q;
    done_d  = 1'b0;
    if (bus.manual) begin
      state_d = IDLE;
      duty_d  = bus.manual_value;
    end else if (!bus.enable) begin
      state_d = IDLE;
      duty_d  = ZERO;
    end else begin
      unique case (state_q)
        IDLE: begin
          duty_d  = ZERO;
          state_d = UP;
        end
        UP: begin
          if (tick) begin
            duty_d = duty_inc;
            if (duty_inc == MAX) begin
              state_d = HOLD_HI;
              hold_d  = '0;
            end
          end
        end
        HOLD_HI: begin
          if (tick) begin
            hold_d = hold_q + H_ONE;
            if (hold_q == H_LAST)
              state_d = DOWN;
          end
        end
        DOWN: begin
          if (tick) begin
            duty_d = duty_dec;
            if (duty_dec == ZERO) begin
              state_d = HOLD_LO;
              hold_d  = '0;
            end
          end
        end
        HOLD_LO: begin
          if (tick) begin
            hold_d = hold_q + H_ONE;
            if (hold_q == H_LAST) begin
              state_d = UP;
              done_d  = 1'b1;
            end
          end
        end
        default: begin
          state_d = IDLE;
          duty_d  = ZERO;
        end
      endcase
    end
  end

  // State, prescaler and hold counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      presc_q <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      hold_q  <= hold_d;
    end
  end

  // Registered duty word and status pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      duty_q <= '0;
      upd_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      duty_q <= duty_d;
      upd_q  <= (duty_d != duty_q);
      busy_q <= (state_d != IDLE);
      done_q <= done_d;
    end
  end

  assign bus.duty        = duty_q;
  assign bus.duty_update = upd_q;
  assign bus.busy        = busy_q;
  assign bus.cycle_done  = done_q;

endmodule
